// File: rtl/control_unit_pkg.sv
// Shared definitions for the control unit: opcodes, ALU codes, instruction
// field positions and the run/halt state encoding.
package control_unit_pkg;

   localparam logic [3:0] OP_NOP  = 4'b0000;
   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_SUB  = 4'b0010;
   localparam logic [3:0] OP_AND  = 4'b0011;
   localparam logic [3:0] OP_OR   = 4'b0100;
   localparam logic [3:0] OP_XOR  = 4'b0101;
   localparam logic [3:0] OP_NOT  = 4'b0110;
   localparam logic [3:0] OP_SHL  = 4'b0111;
   localparam logic [3:0] OP_SHR  = 4'b1000;
   localparam logic [3:0] OP_LOAD = 4'b1001;
   localparam logic [3:0] OP_MOV  = 4'b1010;
   localparam logic [3:0] OP_CMP  = 4'b1011;
   localparam logic [3:0] OP_JMP  = 4'b1100;
   localparam logic [3:0] OP_BEQ  = 4'b1101;
   localparam logic [3:0] OP_RSVD = 4'b1110;
   localparam logic [3:0] OP_HALT = 4'b1111;

   localparam logic [3:0] ALU_PASS = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0010;

   localparam int OPC_MSB  = 15;
   localparam int OPC_LSB  = 12;
   localparam int REG1_MSB = 11;
   localparam int REG1_LSB = 10;
   localparam int REG2_MSB = 9;
   localparam int REG2_LSB = 8;
   localparam int ADR_MSB  = 7;
   localparam int ADR_LSB  = 0;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } cu_state_e;

endpackage

// File: rtl/cu_decoder.sv
// Combinational opcode decoder: opcode plus branch flag to enables and ALU code.
// Opcode 1111 decodes as NOP here; halting is handled by the top level.
module cu_decoder
   import control_unit_pkg::*;
(
   input  logic [3:0] opcode,
   input  logic       branch_check,
   output logic [3:0] alu_code,
   output logic       ram_read,
   output logic       reg_read,
   output logic       reg_write,
   output logic       pc_jump,
   output logic       pc_branch
);

   // Opcode to control-signal mapping
   always_comb begin
      alu_code  = ALU_PASS;
      ram_read  = 1'b0;
      reg_read  = 1'b0;
      reg_write = 1'b0;
      pc_jump   = 1'b0;
      pc_branch = 1'b0;
      case (opcode)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR: begin
            alu_code  = opcode;
            reg_read  = 1'b1;
            reg_write = 1'b1;
         end
         OP_LOAD: begin
            ram_read  = 1'b1;
            reg_write = 1'b1;
         end
         OP_MOV: begin
            reg_read  = 1'b1;
            reg_write = 1'b1;
         end
         OP_CMP: begin
            reg_read = 1'b1;
            alu_code = ALU_SUB;
         end
         OP_JMP: begin
            pc_jump = 1'b1;
         end
         OP_BEQ: begin
            reg_read  = 1'b1;
            alu_code  = ALU_SUB;
            pc_branch = branch_check;
         end
         default: begin
            alu_code = ALU_PASS;
         end
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Control unit top: registered decode outputs plus optional run/halt state.
// Define CU_HALT_EN to build the HALTED state entered by opcode 1111.
module control_unit
   import control_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] instruction,
   input  logic        branch_check,
   output logic [3:0]  alu_code,
   output logic        RAM_read,
   output logic        Reg_read,
   output logic        Reg_write,
   output logic        pc_jump,
   output logic        pc_branch,
   output logic [1:0]  reg1,
   output logic [1:0]  reg2,
   output logic [7:0]  RAM_adr
);

   logic [3:0] dec_alu_s;
   logic       dec_ram_read_s, dec_reg_read_s, dec_reg_write_s, dec_jump_s, dec_branch_s;

   logic [3:0] alu_code_d, alu_code_q;
   logic       ram_read_d, ram_read_q, reg_read_d, reg_read_q, reg_write_d, reg_write_q;
   logic       pc_jump_d, pc_jump_q, pc_branch_d, pc_branch_q;
   logic [1:0] reg1_d, reg1_q, reg2_d, reg2_q;
   logic [7:0] ram_adr_d, ram_adr_q;

   cu_decoder u_dec (
      .opcode       (instruction[OPC_MSB:OPC_LSB]),
      .branch_check (branch_check),
      .alu_code     (dec_alu_s),
      .ram_read     (dec_ram_read_s),
      .reg_read     (dec_reg_read_s),
      .reg_write    (dec_reg_write_s),
      .pc_jump      (dec_jump_s),
      .pc_branch    (dec_branch_s)
   );

`ifdef CU_HALT_EN
   cu_state_e state_d, state_q;
`endif

   // Next-value selection for the output registers and halt state
   always_comb begin
      alu_code_d  = dec_alu_s;
      ram_read_d  = dec_ram_read_s;
      reg_read_d  = dec_reg_read_s;
      reg_write_d = dec_reg_write_s;
      pc_jump_d   = dec_jump_s;
      pc_branch_d = dec_branch_s;
      reg1_d      = instruction[REG1_MSB:REG1_LSB];
      reg2_d      = instruction[REG2_MSB:REG2_LSB];
      ram_adr_d   = instruction[ADR_MSB:ADR_LSB];
`ifdef CU_HALT_EN
      state_d = state_q;
      if (state_q == ST_HALTED) begin
         alu_code_d  = ALU_PASS;
         ram_read_d  = 1'b0;
         reg_read_d  = 1'b0;
         reg_write_d = 1'b0;
         pc_jump_d   = 1'b0;
         pc_branch_d = 1'b0;
         reg1_d      = reg1_q;
         reg2_d      = reg2_q;
         ram_adr_d   = ram_adr_q;
      end else if (instruction[OPC_MSB:OPC_LSB] == OP_HALT) begin
         state_d = ST_HALTED;
      end else begin
         state_d = ST_RUN;
      end
`endif
   end

   // Output registers; reset wins over any instruction at the same edge
   always_ff @(posedge clk) begin
      if (rst) begin
         alu_code_q  <= 4'b0000;
         ram_read_q  <= 1'b0;
         reg_read_q  <= 1'b0;
         reg_write_q <= 1'b0;
         pc_jump_q   <= 1'b0;
         pc_branch_q <= 1'b0;
         reg1_q      <= 2'b00;
         reg2_q      <= 2'b00;
         ram_adr_q   <= 8'h00;
      end else begin
         alu_code_q  <= alu_code_d;
         ram_read_q  <= ram_read_d;
         reg_read_q  <= reg_read_d;
         reg_write_q <= reg_write_d;
         pc_jump_q   <= pc_jump_d;
         pc_branch_q <= pc_branch_d;
         reg1_q      <= reg1_d;
         reg2_q      <= reg2_d;
         ram_adr_q   <= ram_adr_d;
      end
   end

`ifdef CU_HALT_EN
   // Run/halt state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end
`endif

   assign alu_code  = alu_code_q;
   assign RAM_read  = ram_read_q;
   assign Reg_read  = reg_read_q;
   assign Reg_write = reg_write_q;
   assign pc_jump   = pc_jump_q;
   assign pc_branch = pc_branch_q;
   assign reg1      = reg1_q;
   assign reg2      = reg2_q;
   assign RAM_adr   = ram_adr_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: opcode-rule model compared every
// cycle plus hand-computed literal expectations. Halt tests need CU_HALT_EN.
module tb_control_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] instruction = 16'h0000;
   logic        branch_check = 1'b0;
   logic [3:0]  alu_code;
   logic        RAM_read, Reg_read, Reg_write, pc_jump, pc_branch;
   logic [1:0]  reg1, reg2;
   logic [7:0]  RAM_adr;

   int errors = 0;
   int checks = 0;

   // model state
   logic        m_halted = 1'b0;
   logic [20:0] m_out = 21'd0;

`ifdef CU_HALT_EN
   localparam bit HALT_EN = 1'b1;
`else
   localparam bit HALT_EN = 1'b0;
`endif

   control_unit dut (
      .clk(clk), .rst(rst), .instruction(instruction), .branch_check(branch_check),
      .alu_code(alu_code), .RAM_read(RAM_read), .Reg_read(Reg_read), .Reg_write(Reg_write),
      .pc_jump(pc_jump), .pc_branch(pc_branch), .reg1(reg1), .reg2(reg2), .RAM_adr(RAM_adr)
   );

   always #5 clk = ~clk;

   function automatic logic [20:0] dut_vec();
      return {alu_code, RAM_read, Reg_read, Reg_write, pc_jump, pc_branch, reg1, reg2, RAM_adr};
   endfunction

   // Spec rules expressed per opcode value, independent of the RTL structure.
   task automatic model_edge(input logic [15:0] ins, input logic bc, input logic r);
      int op;
      bit alu_op, rr, rw, rd, jmp, br;
      logic [3:0] alu;
      op = int'(ins[15:12]);
      if (r) begin
         m_out = 21'd0;
         m_halted = 1'b0;
      end else if (m_halted) begin
         m_out[20:12] = 9'd0;
      end else if (op == 15 && HALT_EN) begin
         m_out = {9'd0, ins[11:0]};
         m_halted = 1'b1;
      end else begin
         alu_op = (op >= 1 && op <= 8);
         rr  = alu_op || op == 10 || op == 11 || op == 13;
         rw  = alu_op || op == 9 || op == 10;
         rd  = (op == 9);
         jmp = (op == 12);
         br  = (op == 13) && bc;
         alu = alu_op ? ins[15:12] : ((op == 11 || op == 13) ? 4'b0010 : 4'b0000);
         m_out = {alu, rd, rr, rw, jmp, br, ins[11:0]};
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one instruction, advance one edge, compare the whole output vector.
   task automatic step(input logic [15:0] ins, input logic bc, input logic r);
      @(negedge clk);
      instruction  = ins;
      branch_check = bc;
      rst          = r;
      @(posedge clk);
      model_edge(ins, bc, r);
      #1;
      chk("model", {11'd0, dut_vec()}, {11'd0, m_out});
      chk("jump_branch_excl", {31'd0, pc_jump & pc_branch}, 32'd0);
   endtask

   initial begin
      // reset
      step(16'hFFFF, 1'b1, 1'b1);
      chk("reset_all_zero", {11'd0, dut_vec()}, 32'd0);

      // OR: 0100_11_01_00000000
      step(16'b0100_11_01_00000000, 1'b0, 1'b0);
      chk("or_alu", {28'd0, alu_code}, 32'h4);
      chk("or_en", {27'd0, RAM_read, Reg_read, Reg_write, pc_jump, pc_branch}, 32'b01100);
      chk("or_fields", {20'd0, reg1, reg2, RAM_adr}, {20'd0, 2'b11, 2'b01, 8'h00});

      // LOAD: 1001_10_00_10100101
      step(16'b1001_10_00_10100101, 1'b0, 1'b0);
      chk("load_en", {29'd0, RAM_read, Reg_write, Reg_read}, 32'b110);
      chk("load_fields", {22'd0, reg1, RAM_adr}, {22'd0, 2'b10, 8'hA5});

      // BEQ taken / not taken
      step(16'b1101_00_01_00010000, 1'b1, 1'b0);
      chk("beq_taken", {27'd0, pc_branch, alu_code}, {27'd0, 1'b1, 4'b0010});
      step(16'b1101_00_01_00010000, 1'b0, 1'b0);
      chk("beq_not_taken", {31'd0, pc_branch}, 32'd0);

      // JMP
      step(16'b1100_00_00_11110000, 1'b1, 1'b0);
      chk("jmp", {22'd0, pc_jump, pc_branch, RAM_adr}, {22'd0, 1'b1, 1'b0, 8'hF0});

      // reset beats a simultaneous instruction
      step(16'b0001_11_11_11111111, 1'b0, 1'b1);
      chk("rst_priority", {11'd0, dut_vec()}, 32'd0);

      // sweep every opcode with both branch_check values
      for (int op = 0; op < 15; op++) begin
         for (int b = 0; b < 2; b++) begin
            step({op[3:0], 4'(op * 3 + b), 8'(op * 17 + b)}, b[0], 1'b0);
         end
      end
      step(16'hE5A3, 1'b1, 1'b0);
      chk("reserved_nop", {27'd0, alu_code, RAM_read | Reg_read | Reg_write | pc_jump | pc_branch},
          32'd0);

`ifdef CU_HALT_EN
      step(16'b1111_10_01_00111100, 1'b0, 1'b0);
      chk("halt_nop", {27'd0, alu_code, Reg_write}, 32'd0);
      step(16'b0001_01_10_11000011, 1'b0, 1'b0);
      chk("halted_add_no_en", {27'd0, RAM_read, Reg_read, Reg_write, pc_jump, pc_branch}, 32'd0);
      chk("halted_hold", {20'd0, reg1, reg2, RAM_adr}, {20'd0, 2'b10, 2'b01, 8'h3C});
      step(16'b1100_00_00_11110000, 1'b1, 1'b0);
      step(16'b0001_00_00_00000000, 1'b0, 1'b1);
      step(16'b0001_01_10_11000011, 1'b0, 1'b0);
      chk("resume_add", {27'd0, Reg_write, alu_code}, {27'd0, 1'b1, 4'b0001});
`else
      step(16'b1111_10_01_00111100, 1'b1, 1'b0);
      chk("op15_nop", {27'd0, alu_code, Reg_write}, 32'd0);
      step(16'b0001_01_10_11000011, 1'b0, 1'b0);
      chk("op15_no_halt", {27'd0, Reg_write, alu_code}, {27'd0, 1'b1, 4'b0001});
`endif

      // random tail
      for (int i = 0; i < 40; i++) begin
         step(16'($urandom), 1'($urandom), (i % 13 == 12) ? 1'b1 : 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The module SHALL have these ports: clk, input, 1 bit, single system clock, all state updates on its rising edge.
REQ-002 The module SHALL have these ports: rst, input, 1 bit, reset that is synchronous and active-high.
REQ-003 The module SHALL have these ports: instruction, input, 16 bits, instruction word with opcode [15:12], reg1 [11:10], reg2 [9:8], address/immediate [7:0].
REQ-004 The module SHALL have these ports: branch_check, input, 1 bit, branch condition flag from the datapath.
REQ-005 The module SHALL have these ports: alu_code, output, 4 bits, ALU operation select.
REQ-006 The module SHALL have these ports: RAM_read, output, 1 bit, data-RAM read enable.
REQ-007 The module SHALL have these ports: Reg_read, output, 1 bit, register-file read enable.
REQ-008 The module SHALL have these ports: Reg_write, output, 1 bit, register-file write enable.
REQ-009 The module SHALL have these ports: pc_jump, output, 1 bit, unconditional PC load.
REQ-010 The module SHALL have these ports: pc_branch, output, 1 bit, taken-branch PC load.
REQ-011 The module SHALL have these ports: reg1, output, 2 bits, first register index.
REQ-012 The module SHALL have these ports: reg2, output, 2 bits, second register index.
REQ-013 The module SHALL have these ports: RAM_adr, output, 8 bits, RAM address/jump target.

Function
REQ-014 All outputs SHALL be registered, updating on the clk rising edge from the instruction and branch_check values sampled at that edge, with a latency of 1 cycle.
REQ-015 reg1, reg2 and RAM_adr SHALL copy instruction[11:10], instruction[9:8] and instruction[7:0] for every opcode.
REQ-016 Opcode 0000 (NOP) SHALL drive all enables to 0 and alu_code to 0000.
REQ-017 For opcodes 0001 ADD, 0010 SUB, 0011 AND, 0100 OR, 0101 XOR, 0110 NOT, 0111 SHL and 1000 SHR:
- alu_code SHALL equal the opcode.
- Reg_read SHALL be 1 and Reg_write SHALL be 1.
- All other enables SHALL be 0.
REQ-018 Opcode 1001 LOAD SHALL drive RAM_read=1, Reg_write=1, Reg_read=0 and alu_code=0000.
REQ-019 Opcode 1010 MOV SHALL drive Reg_read=1, Reg_write=1 and alu_code=0000.
REQ-020 Opcode 1011 CMP SHALL drive Reg_read=1, Reg_write=0 and alu_code=0010.
REQ-021 Opcode 1100 JMP SHALL drive pc_jump=1, with all other enables 0.
REQ-022 Opcode 1101 BEQ SHALL drive Reg_read=1, alu_code=0010 and pc_branch equal to the branch_check value sampled in the same cycle.
REQ-023 Opcode 1110 (reserved) SHALL decode as NOP.
REQ-024 pc_jump and pc_branch SHALL never both be 1.
REQ-025 The state machine SHALL have two states, RUN and HALTED:
- In RUN, decode SHALL proceed as specified above.
- Opcode 1111 in RUN SHALL drive NOP outputs and move the machine to HALTED.
- In HALTED, all enables SHALL be held 0, and reg1, reg2 and RAM_adr SHALL hold their values, until reset.
REQ-026 If rst and an instruction arrive at the same edge, rst SHALL take priority.

Reset
REQ-027 When rst=1 at a clk edge, every output SHALL be set to 0 (alu_code=0000, RAM_adr=00000000) and the state SHALL be set to RUN.
REQ-028 Reset applied mid-HALTED SHALL return the machine to RUN, and normal decode SHALL resume on the next edge.

Configuration
REQ-029 The macro CU_HALT_EN SHALL control the halt feature:
- When CU_HALT_EN is defined, opcode 1111 and the HALTED state SHALL exist as specified above.
- When CU_HALT_EN is undefined, opcode 1111 SHALL decode as NOP and no state register SHALL be built.

Structure
REQ-030 A shared package control_unit_pkg SHALL hold:
- the 4-bit opcode constants;
- the ALU code constants;
- the instruction field bit positions;
- the state enum.
REQ-031 A combinational sub-module cu_decoder SHALL map opcode plus branch_check to the next enables and alu_code.
REQ-032 The top level SHALL contain only the output registers and the halt state register.

Verification
REQ-033 The bench SHALL cover reset: assert rst for one edge, then check all outputs 0 and state RUN.
REQ-034 The bench SHALL cover OR decode: apply instruction 0100_11_01_00000000 with branch_check=0, then check alu_code=0100, Reg_read=1, Reg_write=1, RAM_read=0, pc_jump=0, pc_branch=0, reg1=11, reg2=01, RAM_adr=00000000 one edge later.
REQ-035 The bench SHALL cover LOAD decode: apply instruction 1001_10_00_10100101, then check RAM_read=1, Reg_write=1, Reg_read=0, reg1=10, RAM_adr=10100101.
REQ-036 The bench SHALL cover BEQ:
- apply instruction 1101_00_01_00010000 with branch_check=1, then check pc_branch=1, alu_code=0010;
- apply the same instruction with branch_check=0, then check pc_branch=0.
REQ-037 The bench SHALL cover JMP: apply instruction 1100_00_00_11110000, then check pc_jump=1, pc_branch=0, RAM_adr=11110000.
REQ-038 The bench SHALL cover halt with CU_HALT_EN defined:
- apply 1111 and then 0001, and check the ADD produces no enables;
- assert rst, then apply 0001, and check Reg_write=1, alu_code=0001.
